// File: rtl/viola_pkg.sv
// Shared constants, entry record and sequencer state encoding for the
// rename/commit sequencer and its entry array.
package viola_pkg;

    localparam int TAG_W = 3;
    localparam int DEPTH = 2**TAG_W - 1;
    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t NO_TAG  = '0;
    localparam tag_t TAG_ONE = tag_t'(1);
    localparam tag_t MAX_TAG = tag_t'(DEPTH);

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  value;
    } entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } seq_state_t;

    // Tags run 1..DEPTH; tag 0 means "no dependency" and is skipped on wrap.
    function automatic tag_t next_tag(input tag_t t);
        return (t == MAX_TAG) ? TAG_ONE : t + TAG_ONE;
    endfunction

endpackage

// File: rtl/rcs_entry_array.sv
// In-flight entry storage: issue write port, writeback write port and a
// combinational head read port. Slot 0 exists only so tags index directly.
module rcs_entry_array
    import viola_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              issue_en,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic              wb_en,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              retire_en,
    input  logic [TAG_W-1:0]  head_tag,
    output entry_t            head_entry
);

    localparam int SLOTS = 2**TAG_W;

    logic [SLOTS-1:0] valid_q;
    logic [SLOTS-1:0] done_q;
    logic [REG_W-1:0] rd_q    [SLOTS];
    logic [XLEN-1:0]  value_q [SLOTS];
    logic             wb_accept;

    // First writeback wins; late or stray results are dropped.
    assign wb_accept = wb_en && (wb_tag != NO_TAG) && valid_q[wb_tag] && !done_q[wb_tag];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            done_q  <= '0;
        end else if (clear) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (issue_en) begin
                valid_q[issue_tag] <= 1'b1;
                done_q[issue_tag]  <= 1'b0;
            end
            if (wb_accept) begin
                done_q[wb_tag] <= 1'b1;
            end
            // Retire last so a bypassed writeback to the head leaves it cleared.
            if (retire_en) begin
                valid_q[head_tag] <= 1'b0;
                done_q[head_tag]  <= 1'b0;
            end
        end
    end

    // NOTE: payload has no reset; valid/done qualify every read of it.
    always_ff @(posedge clk) begin
        if (issue_en) begin
            rd_q[issue_tag] <= issue_rd;
        end
        if (wb_accept) begin
            value_q[wb_tag] <= wb_data;
        end
    end

    always_comb begin
        head_entry       = '0;
        head_entry.valid = valid_q[head_tag];
        head_entry.done  = done_q[head_tag];
        head_entry.rd    = rd_q[head_tag];
        head_entry.value = value_q[head_tag];
    end

endmodule

// File: rtl/rename_commit_sequencer.sv
// In-order tag allocator and commit sequencer feeding the register file.
// Optional macro COMMIT_BYPASS_EN retires a head writeback at the capture edge.
module rename_commit_sequencer
    import viola_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_rd,
    output logic              issue_ready,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [XLEN-1:0]   wb_data,
    output logic              rf_commit,
    output logic [REG_W-1:0]  rf_reg_num,
    output logic [XLEN-1:0]   rf_data,
    output logic [TAG_W-1:0]  rf_num,
    output logic              rf_flush,
    output logic [TAG_W-1:0]  occupancy
);

    seq_state_t      state_q, state_d;
    tag_t            head_q, tail_q, occ_q;
    entry_t          head_entry;
    logic            issue_fire;
    logic            wb_en;
    logic            bypass;
    logic            retire;
    logic [XLEN-1:0] retire_data;

    assign issue_tag = tail_q;
    assign occupancy = occ_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output written here gets a default first, so no latches.
    always_comb begin
        state_d     = state_q;
        issue_ready = 1'b0;
        rf_flush    = 1'b0;
        case (state_q)
            RUN:     issue_ready = (occ_q < MAX_TAG);
            FLUSH:   rf_flush    = 1'b1;
            default: ;
        endcase
        if (flush) begin
            state_d = FLUSH;
        end else if (state_q == FLUSH) begin
            state_d = RUN;
        end
    end

    assign issue_fire = issue_valid && issue_ready && !flush;
    assign wb_en      = wb_valid && (state_q == RUN) && !flush;

`ifdef COMMIT_BYPASS_EN
    assign bypass = wb_en && (wb_tag == head_q) && head_entry.valid && !head_entry.done;
`else
    assign bypass = 1'b0;
`endif

    assign retire      = !flush && head_entry.valid && (head_entry.done || bypass);
    assign retire_data = bypass ? wb_data : head_entry.value;

    rcs_entry_array u_entries (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .issue_en   (issue_fire),
        .issue_tag  (tail_q),
        .issue_rd   (issue_rd),
        .wb_en      (wb_en),
        .wb_tag     (wb_tag),
        .wb_data    (wb_data),
        .retire_en  (retire),
        .head_tag   (head_q),
        .head_entry (head_entry)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= TAG_ONE;
            tail_q     <= TAG_ONE;
            occ_q      <= '0;
            rf_commit  <= 1'b0;
            rf_reg_num <= '0;
            rf_data    <= '0;
            rf_num     <= '0;
        end else if (flush) begin
            head_q    <= TAG_ONE;
            tail_q    <= TAG_ONE;
            occ_q     <= '0;
            rf_commit <= 1'b0;
        end else begin
            if (issue_fire) begin
                tail_q <= next_tag(tail_q);
            end
            if (retire) begin
                head_q <= next_tag(head_q);
            end
            case ({issue_fire, retire})
                2'b10:   occ_q <= occ_q + TAG_ONE;
                2'b01:   occ_q <= occ_q - TAG_ONE;
                default: occ_q <= occ_q;
            endcase
            // x0 retirements consume the slot but never strobe the register file.
            rf_commit <= retire && (head_entry.rd != '0);
            if (retire) begin
                rf_reg_num <= head_entry.rd;
                rf_data    <= retire_data;
                rf_num     <= head_q;
            end
        end
    end

endmodule

// File: tb/tb_rename_commit_sequencer.sv
// Scoreboard bench for rename_commit_sequencer; expected commits are queued
// at stimulus time and popped whenever the DUT strobes rf_commit.
module tb_rename_commit_sequencer;

`ifdef COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [2:0]  issue_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [31:0] wb_data;
    logic        rf_commit;
    logic [4:0]  rf_reg_num;
    logic [31:0] rf_data;
    logic [2:0]  rf_num;
    logic        rf_flush;
    logic [2:0]  occupancy;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    rename_commit_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .issue_tag   (issue_tag),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .rf_commit   (rf_commit),
        .rf_reg_num  (rf_reg_num),
        .rf_data     (rf_data),
        .rf_num      (rf_num),
        .rf_flush    (rf_flush),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // One clock; samples 1 time unit after the edge and scores any commit.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rf_commit === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_commit got rd=%0d data=%h tag=%0d, none expected",
                         rf_reg_num, rf_data, rf_num);
            end else begin
                e = sb.pop_front();
                if ({rf_reg_num, rf_data, rf_num} !== {e.rd, e.data, e.tag}) begin
                    errors++;
                    $display("FAIL commit got rd=%0d data=%h tag=%0d, expected rd=%0d data=%h tag=%0d",
                             rf_reg_num, rf_data, rf_num, e.rd, e.data, e.tag);
                end
            end
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic [2:0] tag);
        exp_t e;
        e.rd = rd; e.data = data; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic do_issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [2:0] tag, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_tag   = tag;
        wb_data  = data;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d commits outstanding, expected 0", name, sb.size());
        end
    endtask

    task automatic wait_commit(input string name, input int budget);
        int n = 0;
        while (rf_commit !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (rf_commit !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait got rf_commit=%b, expected 1 within %0d cycles", name, rf_commit, budget);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_data = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rf_commit, rf_reg_num, rf_data, rf_num, rf_flush, occupancy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got commit=%b rd=%0d data=%h num=%0d flush=%b occ=%0d, expected all 0",
                     rf_commit, rf_reg_num, rf_data, rf_num, rf_flush, occupancy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || issue_tag !== 3'd1) begin
            errors++;
            $display("FAIL reset_issue got ready=%b tag=%0d, expected ready=1 tag=1", issue_ready, issue_tag);
        end
    endtask

    task automatic test_in_order();
        logic [4:0]  rds [3] = '{5'd5, 5'd6, 5'd7};
        logic [31:0] dat [3] = '{32'h11, 32'h22, 32'h33};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (issue_tag !== 3'(i + 1) || issue_ready !== 1'b1) begin
                errors++;
                $display("FAIL inorder_tag got tag=%0d ready=%b, expected tag=%0d ready=1", issue_tag, issue_ready, i + 1);
            end
            push(rds[i], dat[i], 3'(i + 1));
            do_issue(rds[i]);
        end
        checks++;
        if (occupancy !== 3'd3) begin
            errors++;
            $display("FAIL inorder_occ got %0d, expected 3", occupancy);
        end
        do_wb(3'd3, 32'h33);
        checks++;
        if (rf_commit !== 1'b0) begin
            errors++;
            $display("FAIL inorder_wb3 got rf_commit=%b, expected 0", rf_commit);
        end
        do_wb(3'd1, 32'h11);
        checks++;
        if (rf_commit !== BYP) begin
            errors++;
            $display("FAIL inorder_wb1 got rf_commit=%b, expected %b", rf_commit, BYP);
        end
        do_wb(3'd2, 32'h22);
        checks++;
        if (rf_commit !== 1'b1) begin
            errors++;
            $display("FAIL inorder_seq1 got rf_commit=%b, expected 1", rf_commit);
        end
        tick();
        checks++;
        if (rf_commit !== 1'b1) begin
            errors++;
            $display("FAIL inorder_seq2 got rf_commit=%b, expected 1", rf_commit);
        end
        if (!BYP) begin
            tick();
            checks++;
            if (rf_commit !== 1'b1) begin
                errors++;
                $display("FAIL inorder_seq3 got rf_commit=%b, expected 1", rf_commit);
            end
        end
        tick();
        checks++;
        if (rf_commit !== 1'b0 || occupancy !== 3'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL inorder_end got commit=%b occ=%0d pending=%0d, expected 0/0/0",
                     rf_commit, occupancy, sb.size());
        end
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 1; i <= 7; i++) begin
            checks++;
            if (issue_tag !== 3'(i)) begin
                errors++;
                $display("FAIL full_tag got %0d, expected %0d", issue_tag, i);
            end
            do_issue(5'(i));
        end
        checks++;
        if (issue_ready !== 1'b0 || occupancy !== 3'd7) begin
            errors++;
            $display("FAIL full_state got ready=%b occ=%0d, expected ready=0 occ=7", issue_ready, occupancy);
        end
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        tick();
        issue_valid = 1'b0;
        checks++;
        if (occupancy !== 3'd7 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got occ=%0d ready=%b, expected occ=7 ready=0", occupancy, issue_ready);
        end
        push(5'd1, 32'h100, 3'd1);
        do_wb(3'd1, 32'h100);
        wait_commit("full", 4);
        checks++;
        if (occupancy !== 3'd6 || issue_ready !== 1'b1 || issue_tag !== 3'd1) begin
            errors++;
            $display("FAIL wrap_state got occ=%0d ready=%b tag=%0d, expected occ=6 ready=1 tag=1",
                     occupancy, issue_ready, issue_tag);
        end
        do_issue(5'd9);
        checks++;
        if (occupancy !== 3'd7 || issue_tag === 3'd0) begin
            errors++;
            $display("FAIL wrap_issue got occ=%0d tag=%0d, expected occ=7 and nonzero tag", occupancy, issue_tag);
        end
        for (int i = 2; i <= 7; i++) begin
            push(5'(i), 32'h200 + 32'(i), 3'(i));
            do_wb(3'(i), 32'h200 + 32'(i));
        end
        push(5'd9, 32'h909, 3'd1);
        do_wb(3'd1, 32'h909);
        drain("wrap", 20);
    endtask

    task automatic test_rd_zero();
        apply_reset();
        do_issue(5'd0);
        checks++;
        if (occupancy !== 3'd1) begin
            errors++;
            $display("FAIL x0_occ got %0d, expected 1", occupancy);
        end
        do_wb(3'd1, 32'hDEAD);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rf_commit !== 1'b0) begin
                errors++;
                $display("FAIL x0_commit got rf_commit=%b, expected 0", rf_commit);
            end
            tick();
        end
        checks++;
        if (occupancy !== 3'd0 || rf_commit !== 1'b0) begin
            errors++;
            $display("FAIL x0_retired got occ=%0d commit=%b, expected occ=0 commit=0", occupancy, rf_commit);
        end
        push(5'd4, 32'h44, 3'd2);
        do_issue(5'd4);
        do_wb(3'd2, 32'h44);
        drain("x0", 6);
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 1; i <= 4; i++) do_issue(5'(i));
        do_wb(3'd2, 32'h22);
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd20;
        tick();
        flush       = 1'b0;
        issue_valid = 1'b0;
        checks++;
        if (rf_flush !== 1'b1 || issue_ready !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL flush_cycle got rf_flush=%b ready=%b occ=%0d, expected 1/0/0",
                     rf_flush, issue_ready, occupancy);
        end
        wb_valid = 1'b1; wb_tag = 3'd2; wb_data = 32'hBAD0;
        tick();
        wb_valid = 1'b0;
        checks++;
        if (rf_flush !== 1'b0 || issue_ready !== 1'b1 || issue_tag !== 3'd1 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL flush_after got rf_flush=%b ready=%b tag=%0d occ=%0d, expected 0/1/1/0",
                     rf_flush, issue_ready, issue_tag, occupancy);
        end
        do_wb(3'd2, 32'hBAD1);
        push(5'd3, 32'h77, 3'd1);
        do_issue(5'd3);
        do_issue(5'd8);
        do_wb(3'd1, 32'h77);
        drain("flush1", 6);
        repeat (3) tick();
        checks++;
        if (occupancy !== 3'd1) begin
            errors++;
            $display("FAIL flush_stale got occ=%0d, expected 1", occupancy);
        end
        push(5'd8, 32'h88, 3'd2);
        do_wb(3'd2, 32'h88);
        drain("flush2", 6);
    endtask

    task automatic test_duplicate_wb();
        apply_reset();
        push(5'd10, 32'h1, 3'd1);
        push(5'd11, 32'hA, 3'd2);
        do_issue(5'd10);
        do_issue(5'd11);
        do_wb(3'd2, 32'hA);
        do_wb(3'd2, 32'hB);
        do_wb(3'd1, 32'h1);
        drain("dup", 6);
    endtask

    task automatic test_latency_and_reset();
        apply_reset();
        do_issue(5'd12);
        tick();
        push(5'd12, 32'hC0DE, 3'd1);
        do_wb(3'd1, 32'hC0DE);
        checks++;
        if (rf_commit !== BYP) begin
            errors++;
            $display("FAIL latency_e1 got rf_commit=%b, expected %b", rf_commit, BYP);
        end
        if (!BYP) begin
            tick();
            checks++;
            if (rf_commit !== 1'b1) begin
                errors++;
                $display("FAIL latency_e2 got rf_commit=%b, expected 1", rf_commit);
            end
        end
        tick();
        checks++;
        if (rf_commit !== 1'b0) begin
            errors++;
            $display("FAIL latency_strobe got rf_commit=%b, expected 0", rf_commit);
        end
        do_issue(5'd13);
        do_issue(5'd14);
        push(5'd13, 32'h5, 3'd2);
        do_wb(3'd2, 32'h5);
        wait_commit("midrst", 4);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({rf_commit, rf_reg_num, rf_data, rf_num, rf_flush, occupancy} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got commit=%b rd=%0d data=%h num=%0d flush=%b occ=%0d, expected all 0",
                     rf_commit, rf_reg_num, rf_data, rf_num, rf_flush, occupancy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (issue_tag !== 3'd1 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_issue got tag=%0d ready=%b, expected tag=1 ready=1", issue_tag, issue_ready);
        end
        tick();
        checks++;
        if (rf_flush !== 1'b0 || rf_commit !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet got rf_flush=%b commit=%b, expected 0/0", rf_flush, rf_commit);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_rd_zero();
        test_flush();
        test_duplicate_wb();
        test_latency_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
